// File: rtl/rvx_spi_subordinate_if.sv
// Register bus between a host and the SPI subordinate: one-cycle request/acknowledge
// read and write channels sharing a single register address.
interface rvx_spi_subordinate_if;
  logic [4:0]  rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address, read_request, write_data, write_strobe, write_request,
    input  read_data, read_response, write_response
  );

  modport slave (
    input  rw_address, read_request, write_data, write_strobe, write_request,
    output read_data, read_response, write_response
  );
endinterface

// File: rtl/rvx_spi_subordinate.sv
// SPI subordinate (modes 0-3) with MODE/TX/RX/STATUS registers; SPI pins are oversampled
// by the system clock (ratio >= 4), bus accesses acknowledge one cycle after request.
module rvx_spi_subordinate (
  input  logic                        clock,
  input  logic                        reset,
  rvx_spi_subordinate_if.slave        bus,
  input  logic                        sclk,
  input  logic                        mosi,
  output logic                        miso,
  input  logic                        cs
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        cs_s1, cs_s2, sclk_s1, sclk_s2, sclk_prev, mosi_s1, mosi_s2;
  logic        sync_v1, sync_v2, cs_high_seen;
  logic        cpol, cpha;
  logic [7:0]  tx_reg, rx_reg, tx_shift, rx_shift, rx_next;
  logic [2:0]  bit_count;
  logic        rx_valid, overrun, tx_empty;
  logic        start, stop, busy, run;
  logic        sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic        sample_edge, shift_edge, byte_done, write_en, rx_read;
  logic        unused_write_bits;

  assign unused_write_bits = &{1'b0, bus.write_data[31:8]};

  // A fall is only honoured after cs has been seen high on real samples, so a cs
  // held low through reset does not look like a new transfer.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    case (state_q)
      IDLE: if (sync_v2 && cs_high_seen && !cs_s2) begin
        state_d = ACTIVE;
        start   = 1'b1;
      end
      ACTIVE: if (cs_s2) begin
        state_d = IDLE;
        stop    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign busy        = (state_q == ACTIVE);
  assign run         = busy && !cs_s2;
  assign sclk_rise   = sclk_s2 & ~sclk_prev;
  assign sclk_fall   = ~sclk_s2 & sclk_prev;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = run && (cpha ? trail_edge : lead_edge);
  // bit_count==0 marks a byte boundary: the MSB is already on miso, so no shift there.
  assign shift_edge  = run && (cpha ? lead_edge : trail_edge) && (bit_count != 3'd0);
  assign byte_done   = sample_edge && (bit_count == 3'd7);
  assign rx_next     = {rx_shift[6:0], mosi_s2};
  assign write_en    = bus.write_request && (bus.write_strobe == 4'hF);
  assign rx_read     = bus.read_request && (bus.rw_address == 5'd8);
  assign miso        = busy ? tx_shift[7] : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_s1 <= 1'b1;  cs_s2 <= 1'b1;
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_prev <= 1'b0;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
      sync_v1 <= 1'b0; sync_v2 <= 1'b0; cs_high_seen <= 1'b0;
      bus.read_data <= '0; bus.read_response <= 1'b0; bus.write_response <= 1'b0;
      cpol <= 1'b0; cpha <= 1'b0;
      tx_reg <= '0; rx_reg <= '0; tx_shift <= '0; rx_shift <= '0;
      bit_count <= '0; rx_valid <= 1'b0; overrun <= 1'b0; tx_empty <= 1'b1;
    end else begin
      cs_s1 <= cs;    cs_s2 <= cs_s1;
      sclk_s1 <= sclk; sclk_s2 <= sclk_s1; sclk_prev <= sclk_s2;
      mosi_s1 <= mosi; mosi_s2 <= mosi_s1;
      sync_v1 <= 1'b1; sync_v2 <= sync_v1;
      if (start)                  cs_high_seen <= 1'b0;
      else if (sync_v2 && cs_s2)  cs_high_seen <= 1'b1;

      bus.read_response  <= bus.read_request;
      bus.write_response <= bus.write_request;
      bus.read_data      <= '0;
      if (bus.read_request) begin
        case (bus.rw_address)
          5'd0:    bus.read_data <= {30'd0, cpol, cpha};
          5'd4:    bus.read_data <= {24'd0, tx_reg};
          5'd8:    bus.read_data <= {24'd0, rx_reg};
          5'd12:   bus.read_data <= {28'd0, overrun, tx_empty, rx_valid, busy};
          default: bus.read_data <= '0;
        endcase
      end

      if (start) begin
        bit_count <= '0;
        tx_shift  <= tx_reg;
        tx_empty  <= 1'b1;
      end else if (stop) begin
        bit_count <= '0;
      end else begin
        if (sample_edge) begin
          rx_shift  <= rx_next;
          bit_count <= bit_count + 3'd1;
        end
        if (byte_done) begin
          tx_shift <= tx_reg;
          tx_empty <= 1'b1;
        end else if (shift_edge) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end

      // Register writes come after the shifter load so a same-cycle TX write wins tx_empty.
      if (write_en) begin
        case (bus.rw_address)
          5'd0:    if (!busy) {cpol, cpha} <= bus.write_data[1:0];
          5'd4:    begin tx_reg <= bus.write_data[7:0]; tx_empty <= 1'b0; end
          5'd12:   if (bus.write_data[3]) overrun <= 1'b0;
          default: ;
        endcase
      end

      if (rx_read) rx_valid <= 1'b0;
      if (!start && !stop && byte_done) begin
        rx_reg   <= rx_next;
        rx_valid <= 1'b1;
        if (rx_valid) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvx_spi_subordinate.sv
// Bench for rvx_spi_subordinate: a cycle-stepped SPI manager plus a transaction-level
// register model predicting what each byte exchange and bus access should produce.
module tb_rvx_spi_subordinate;
  localparam int H = 4;

  logic clock = 1'b0;
  logic reset, sclk, mosi, cs, miso;
  int   checks = 0;
  int   errors = 0;

  rvx_spi_subordinate_if bus ();

  rvx_spi_subordinate dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .cs    (cs)
  );

  always #5 clock = ~clock;

  logic       m_cpol, m_cpha, m_busy, m_rx_valid, m_overrun, m_tx_empty;
  logic [7:0] m_tx, m_rx, exp_out;

  function automatic logic [31:0] exp_status();
    return {28'd0, m_overrun, m_tx_empty, m_rx_valid, m_busy};
  endfunction

  task automatic m_reset();
    m_cpol = 0; m_cpha = 0; m_busy = 0; m_rx_valid = 0; m_overrun = 0;
    m_tx_empty = 1; m_tx = 0; m_rx = 0; exp_out = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic ack);
    bus.rw_address = a; bus.write_data = d; bus.write_strobe = s; bus.write_request = 1;
    tick(1);
    bus.write_request = 0; bus.write_strobe = 0;
    ack = bus.write_response;
    if (s == 4'hF) begin
      case (a)
        5'd0:    if (!m_busy) begin m_cpol = d[1]; m_cpha = d[0]; end
        5'd4:    begin m_tx = d[7:0]; m_tx_empty = 0; end
        5'd12:   if (d[3]) m_overrun = 0;
        default: ;
      endcase
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic ack);
    bus.rw_address = a; bus.read_request = 1;
    tick(1);
    bus.read_request = 0;
    d = bus.read_data;
    ack = bus.read_response;
    if (a == 5'd8) m_rx_valid = 0;
  endtask

  // Model effect of one completed byte: new RX, overrun if unread, shifter reloads from TX.
  task automatic byte_done_model(input logic [7:0] sent);
    m_overrun  = m_overrun | m_rx_valid;
    m_rx       = sent;
    m_rx_valid = 1;
    m_tx_empty = 1;
    exp_out    = m_tx;
  endtask

  task automatic cs_low();
    sclk = m_cpol;
    tick(4);
    cs = 0;
    m_busy = 1; m_tx_empty = 1; exp_out = m_tx;
    tick(8);
  endtask

  task automatic cs_high();
    tick(H);
    cs = 1;
    m_busy = 0;
    tick(8);
  endtask

  task automatic spi_bits(input logic [7:0] out, input int n, output logic [7:0] got);
    got = 0;
    for (int i = 0; i < n; i++) begin
      if (!m_cpha) begin
        mosi = out[7-i]; tick(H);
        got = {got[6:0], miso}; sclk = ~m_cpol; tick(H);
        sclk = m_cpol;
      end else begin
        sclk = ~m_cpol; mosi = out[7-i]; tick(H);
        got = {got[6:0], miso}; sclk = m_cpol; tick(H);
      end
    end
  endtask

  task automatic xfer(input logic [7:0] out, output logic [7:0] got, output logic [7:0] ex);
    ex = exp_out;
    spi_bits(out, 8, got);
    byte_done_model(out);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic ack;
    reset = 1;
    tick(3);
    checks += 4;
    if (bus.read_response !== 1'b0) begin errors++; $display("FAIL reset_rresp: got %b expected 0", bus.read_response); end
    if (bus.write_response !== 1'b0) begin errors++; $display("FAIL reset_wresp: got %b expected 0", bus.write_response); end
    if (bus.read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.read_data); end
    if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    reset = 0;
    m_reset();
    tick(4);
    rd(5'd0, d, ack); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_mode: got %h expected 0", d); end
    rd(5'd4, d, ack); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_tx: got %h expected 0", d); end
    rd(5'd8, d, ack); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_rx: got %h expected 0", d); end
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL reset_status: got %h expected %h", d, exp_status()); end
  endtask

  task automatic test_modes();
    logic [31:0] d;
    logic ack;
    logic [7:0] got, ex;
    for (int m = 0; m < 4; m++) begin
      wr(5'd0, m, 4'hF, ack);
      rd(5'd0, d, ack); checks++;
      if (d !== m) begin errors++; $display("FAIL mode_write: got %h expected %h", d, m); end
      wr(5'd4, 32'hA5, 4'hF, ack);
      cs_low();
      wr(5'd0, ~m & 3, 4'hF, ack);
      xfer(8'h3C, got, ex);
      cs_high();
      checks++;
      if (got !== ex) begin errors++; $display("FAIL mode%0d_miso: got %h expected %h", m, got, ex); end
      rd(5'd12, d, ack); checks++;
      if (d !== exp_status()) begin errors++; $display("FAIL mode%0d_status: got %h expected %h", m, d, exp_status()); end
      rd(5'd8, d, ack); checks++;
      if (d !== {24'd0, m_rx}) begin errors++; $display("FAIL mode%0d_rx: got %h expected %h", m, d, m_rx); end
      rd(5'd0, d, ack); checks++;
      if (d !== {30'd0, m_cpol, m_cpha}) begin errors++; $display("FAIL mode%0d_busy_write: got %h expected %h", m, d, {m_cpol, m_cpha}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic ack;
    logic [7:0] got, ex, r;
    wr(5'd0, 0, 4'hF, ack);
    rd(5'd8, d, ack);
    wr(5'd4, 32'hA5, 4'hF, ack);
    cs_low();
    wr(5'd4, 32'h5A, 4'hF, ack);
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL b2b_status_busy: got %h expected %h", d, exp_status()); end
    xfer(8'h3C, got, ex); checks++;
    if (got !== ex) begin errors++; $display("FAIL b2b_byte1: got %h expected %h", got, ex); end
    r = 8'($urandom);
    xfer(r, got, ex); checks++;
    if (got !== ex) begin errors++; $display("FAIL b2b_byte2: got %h expected %h", got, ex); end
    cs_high();
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL b2b_overrun: got %h expected %h", d, exp_status()); end
    rd(5'd8, d, ack); checks++;
    if (d !== {24'd0, r}) begin errors++; $display("FAIL b2b_rx: got %h expected %h", d, r); end
    wr(5'd12, 32'd8, 4'hF, ack);
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL b2b_w1c: got %h expected %h", d, exp_status()); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic ack;
    logic [7:0] got, ex, p, q;
    wr(5'd0, 0, 4'hF, ack);
    rd(5'd8, d, ack);
    p = 8'($urandom);
    cs_low(); xfer(p, got, ex); cs_high();
    cs_low(); spi_bits(8'($urandom), 5, got); cs_high();
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL abort_status: got %h expected %h", d, exp_status()); end
    rd(5'd8, d, ack); checks++;
    if (d !== {24'd0, p}) begin errors++; $display("FAIL abort_rx: got %h expected %h", d, p); end
    wr(5'd4, $urandom, 4'hF, ack);
    q = 8'($urandom);
    cs_low(); xfer(q, got, ex); cs_high();
    checks++;
    if (got !== ex) begin errors++; $display("FAIL abort_next_miso: got %h expected %h", got, ex); end
    rd(5'd8, d, ack); checks++;
    if (d !== {24'd0, q}) begin errors++; $display("FAIL abort_next_rx: got %h expected %h", d, q); end
  endtask

  task automatic test_rx_read_collision();
    logic [31:0] d;
    logic ack;
    logic [7:0] got, ex, o, n;
    wr(5'd0, 0, 4'hF, ack);
    o = 8'($urandom);
    cs_low(); xfer(o, got, ex); cs_high();
    n = 8'($urandom);
    cs_low();
    spi_bits(n, 7, got);
    mosi = n[0]; tick(H);
    sclk = 1; tick(2);
    bus.rw_address = 5'd8; bus.read_request = 1;
    tick(1);
    bus.read_request = 0;
    checks += 2;
    if (bus.read_response !== 1'b1) begin errors++; $display("FAIL coll_ack: got %b expected 1", bus.read_response); end
    if (bus.read_data !== {24'd0, o}) begin errors++; $display("FAIL coll_old_rx: got %h expected %h", bus.read_data, o); end
    tick(H - 3);
    sclk = 0;
    byte_done_model(n);
    cs_high();
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL coll_status: got %h expected %h", d, exp_status()); end
    rd(5'd8, d, ack); checks++;
    if (d !== {24'd0, n}) begin errors++; $display("FAIL coll_new_rx: got %h expected %h", d, n); end
    wr(5'd12, 32'd8, 4'hF, ack);
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic ack;
    wr(5'd4, 32'hFFFF_FFC3, 4'hF, ack);
    wr(5'd4, 32'h0000_0011, 4'h3, ack); checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL bus_partial_ack: got %b expected 1", ack); end
    wr(5'd0, 32'd3, 4'h3, ack);
    rd(5'd4, d, ack); checks++;
    if (d !== {24'd0, m_tx}) begin errors++; $display("FAIL bus_partial_tx: got %h expected %h", d, m_tx); end
    tick(1); checks++;
    if (bus.read_data !== 32'd0) begin errors++; $display("FAIL bus_idle_rdata: got %h expected 0", bus.read_data); end
    rd(5'd0, d, ack); checks++;
    if (d !== {30'd0, m_cpol, m_cpha}) begin errors++; $display("FAIL bus_partial_mode: got %h expected %h", d, {m_cpol, m_cpha}); end
    rd(5'd20, d, ack); checks += 2;
    if (d !== 32'd0) begin errors++; $display("FAIL bus_unmapped: got %h expected 0", d); end
    if (ack !== 1'b1) begin errors++; $display("FAIL bus_unmapped_ack: got %b expected 1", ack); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ack;
    logic [7:0] got, ex, s;
    wr(5'd0, 0, 4'hF, ack);
    wr(5'd4, $urandom, 4'hF, ack);
    cs_low();
    spi_bits(8'($urandom), 3, got);
    reset = 1; tick(2); reset = 0;
    m_reset();
    tick(4);
    spi_bits(8'hFF, 8, got); checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL rstmid_miso: got %h expected 00", got); end
    rd(5'd12, d, ack); checks++;
    if (d !== exp_status()) begin errors++; $display("FAIL rstmid_status: got %h expected %h", d, exp_status()); end
    rd(5'd8, d, ack); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL rstmid_rx: got %h expected 0", d); end
    cs_high();
    wr(5'd4, $urandom, 4'hF, ack);
    s = 8'($urandom);
    cs_low(); xfer(s, got, ex); cs_high();
    checks++;
    if (got !== ex) begin errors++; $display("FAIL rstmid_next_miso: got %h expected %h", got, ex); end
    rd(5'd8, d, ack); checks++;
    if (d !== {24'd0, s}) begin errors++; $display("FAIL rstmid_next_rx: got %h expected %h", d, s); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic ack;
    logic [7:0] got, ex, s;
    repeat (6) begin
      wr(5'd0, $urandom_range(0, 3), 4'hF, ack);
      wr(5'd4, $urandom, 4'hF, ack);
      s = 8'($urandom);
      cs_low(); xfer(s, got, ex); cs_high();
      checks++;
      if (got !== ex) begin errors++; $display("FAIL rand_miso: got %h expected %h", got, ex); end
      rd(5'd12, d, ack); checks++;
      if (d !== exp_status()) begin errors++; $display("FAIL rand_status: got %h expected %h", d, exp_status()); end
      rd(5'd8, d, ack); checks++;
      if (d !== {24'd0, s}) begin errors++; $display("FAIL rand_rx: got %h expected %h", d, s); end
    end
  endtask

  initial begin
    bus.rw_address = 0; bus.write_data = 0; bus.write_strobe = 0;
    bus.read_request = 0; bus.write_request = 0;
    cs = 1; sclk = 0; mosi = 0; reset = 1;
    m_reset();
    test_reset();
    test_modes();
    test_back_to_back();
    test_abort();
    test_rx_read_collision();
    test_bus();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
